// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key schedule: word/block types,
// the forward S-box, RotWord/SubWord and the round-constant table.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned IDX_W = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } inv_ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is unused; rounds 1..10 follow.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
        logic [7:0] val;
        val = 8'h00;
        if (r <= 4'd10) begin
            val = RCON[r];
        end
        return val;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule: round-r key in,
// round-(r-1) key out. Purely combinational.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [3:0]   idx_i,
    output logic [127:0] prev_o
);

    word_t w0, w1, w2, w3;
    word_t p0, p1, p2, p3;

    assign {w0, w1, w2, w3} = key_i;

    // Words 1..3 unwind by XOR; word 0 needs the recovered p3 through the g() function.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon(idx_i), 24'h000000};

    assign prev_o = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_inv_key_expand.sv
// Iterative AES-128 inverse key schedule: takes the round-10 key and emits
// round keys 10 down to 0, one per accepted beat.
module aes_inv_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter bit          CLEAR_IDLE = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx_o,
    output logic         rk_last_o
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_inv_key_expand supports only NUM_ROUNDS = 10 (AES-128)");
    end

    inv_ks_state_e    state_q;
    block_t           key_q;
    logic [IDX_W-1:0] idx_q;
    block_t           prev_key;

    aes_inv_key_step u_step (
        .key_i  (key_q),
        .idx_i  (idx_q),
        .prev_o (prev_key)
    );

    // Reset outranks flush, flush outranks every handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            if (CLEAR_IDLE) begin
                key_q <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid_i) begin
                        key_q   <= key_i;
                        idx_q   <= IDX_W'(NUM_ROUNDS);
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready_i) begin
                        if (idx_q != '0) begin
                            key_q <= prev_key;
                            idx_q <= idx_q - 4'd1;
                        end else begin
                            state_q <= IDLE;
                            if (CLEAR_IDLE) begin
                                key_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Round-key outputs come straight from registers; rk_ready_i never reaches them.
    assign rk_valid_o  = (state_q == EMIT);
    assign rk_o        = key_q;
    assign rk_idx_o    = idx_q;
    assign rk_last_o   = (state_q == EMIT) && (idx_q == '0);
    assign key_ready_o = (state_q == IDLE) && !flush_i && !rst_i;

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Bench for aes_inv_key_expand: step-function vector table plus a
// scoreboard-driven check of the streaming interface.
module tb_aes_inv_key_expand;

    logic         clk = 1'b0;
    logic         rst_i, flush_i, key_valid_i, rk_ready_i;
    logic         key_ready_o, rk_valid_o, rk_last_o;
    logic [127:0] key_i, rk_o;
    logic [3:0]   rk_idx_o;

    logic [127:0] st_key, st_prev;
    logic [3:0]   st_idx;

    always #5 clk = ~clk;

    aes_inv_key_expand #(
        .NUM_ROUNDS (10),
        .CLEAR_IDLE (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .key_valid_i (key_valid_i),
        .key_ready_o (key_ready_o),
        .key_i       (key_i),
        .rk_valid_o  (rk_valid_o),
        .rk_ready_i  (rk_ready_i),
        .rk_o        (rk_o),
        .rk_idx_o    (rk_idx_o),
        .rk_last_o   (rk_last_o)
    );

    aes_inv_key_step u_step_ut (
        .key_i  (st_key),
        .idx_i  (st_idx),
        .prev_o (st_prev)
    );

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] prev;
    } step_vec_t;

    exp_t         sb[$];
    step_vec_t    step_tab[10];
    logic [127:0] rk_tab[11];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_acc = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Sampled mid-cycle: compare against the queue head, pop on handshake, push on key acceptance.
    task automatic monitor();
        exp_t e;
        if (!mon_en) return;
        chk("rk_valid", 128'(rk_valid_o), 128'(sb.size() != 0));
        chk("key_ready", 128'(key_ready_o), 128'((sb.size() == 0) && !flush_i && !rst_i));
        if (sb.size() != 0) begin
            e = sb[0];
            chk("rk", rk_o, e.rk);
            chk("rk_idx", 128'(rk_idx_o), 128'(e.idx));
            chk("rk_last", 128'(rk_last_o), 128'(e.last));
            if (rk_ready_i) sb.pop_front();
        end else begin
            chk("idle_rk", rk_o, 128'h0);
            chk("idle_idx", 128'(rk_idx_o), 128'h0);
            chk("idle_last", 128'(rk_last_o), 128'h0);
        end
        if (flush_i || rst_i) begin
            sb.delete();
        end else if (key_valid_i && key_ready_o) begin
            n_acc++;
            for (int r = 10; r >= 0; r--) begin
                sb.push_back('{rk_tab[r], 4'(r), (r == 0)});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget, input bit rand_ready);
        int i;
        for (i = 0; i < budget && sb.size() != 0; i++) begin
            if (rand_ready) rk_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: timeout with %0d beats outstanding", name, sb.size());
            sb.delete();
        end
        rk_ready_i = 1'b1;
        step();
    endtask

    task automatic wait_idx(input string name, input logic [3:0] idx);
        int i;
        for (i = 0; i < 40 && !(rk_valid_o && rk_idx_o == idx); i++) step();
        if (!(rk_valid_o && rk_idx_o == idx)) begin
            n_err++;
            $display("FAIL %s: idx %0d never reached, at %0d", name, idx, rk_idx_o);
        end
    endtask

    initial begin
        int acc0;
        rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int r = 1; r <= 10; r++) begin
            step_tab[r-1] = '{rk_tab[r], 4'(r), rk_tab[r-1]};
        end

        rst_i = 1'b1; flush_i = 1'b0; key_valid_i = 1'b0; rk_ready_i = 1'b1;
        key_i = '0; st_key = '0; st_idx = '0;

        // Step function alone: every round, every Rcon.
        for (int i = 0; i < 10; i++) begin
            st_key = step_tab[i].key;
            st_idx = step_tab[i].idx;
            #1;
            chk($sformatf("step_r%0d", step_tab[i].idx), st_prev, step_tab[i].prev);
        end

        repeat (3) step();
        rst_i = 1'b0;
        mon_en = 1'b1;
        step();

        // Full-throughput stream.
        key_i = rk_tab[10]; key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0; key_i = {$urandom, $urandom, $urandom, $urandom};
        drain("stream_full", 20, 1'b0);

        // Random backpressure.
        key_i = rk_tab[10]; key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0;
        drain("stream_bp", 300, 1'b1);

        // Back-to-back: key_valid held from the first stream's start.
        acc0 = n_acc;
        key_i = rk_tab[10]; key_valid_i = 1'b1;
        for (int i = 0; i < 60 && n_acc < acc0 + 2; i++) step();
        key_valid_i = 1'b0;
        chk("b2b_accepts", 128'(n_acc - acc0), 128'd2);
        drain("stream_b2b", 20, 1'b0);

        // Flush at idx 6, then restart.
        key_i = rk_tab[10]; key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0;
        wait_idx("flush_wait", 4'd6);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0;
        drain("stream_after_flush", 20, 1'b0);

        // Reset at idx 3 with flush and a competing key.
        key_i = rk_tab[10]; key_valid_i = 1'b1;
        step();
        key_valid_i = 1'b0;
        wait_idx("reset_wait", 4'd3);
        rst_i = 1'b1; flush_i = 1'b1; key_valid_i = 1'b1;
        step();
        rst_i = 1'b0; flush_i = 1'b0; key_valid_i = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_expand.md
Name: aes_inv_key_expand

Overview:
Iterative AES-128 inverse key schedule generator for the decryption datapath. It accepts the final (round-10) round key and walks the key schedule backwards. It emits round keys 10, 9, …, 0, one per accepted beat, in the order the inverse cipher consumes them. The block sits between key storage and the inverse-round engine. Its round-key output feeds the decryption-side AddRoundKey stage.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is legal; elaboration-time assertion on any other value.
- CLEAR_IDLE, 1, when 1 the key register and rk_o are zeroed on return to IDLE, so no key material is left behind.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous abort; returns the block to IDLE.
- key_valid_i  input  1  a round-10 key is offered on key_i.
- key_ready_o  output  1  block can accept a key.
- key_i  input  128  round-10 key. [127:96] = w0, big-endian bytes, FIPS-197 order.
- rk_valid_o  output  1  rk_o holds a valid round key.
- rk_ready_i  input  1  consumer accepts rk_o this cycle.
- rk_o  output  128  current round key, same word/byte order as key_i.
- rk_idx_o  output  4  round index of rk_o (10 down to 0).
- rk_last_o  output  1  high when rk_idx_o == 0 and rk_valid_o is high.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE; key reg=0; idx=0; rk_valid_o=0; rk_o=0; rk_idx_o=0; rk_last_o=0; key_ready_o=1 after reset deasserts.
- FSM states: IDLE, EMIT.
- IDLE:
  - key_ready_o = ~flush_i.
  - On key_valid_i & key_ready_o: key reg <= key_i, idx <= 10, state <= EMIT.
  - rk_valid_o rises the following cycle.
- EMIT:
  - key_ready_o = 0; rk_valid_o = 1.
  - rk_o = key reg; rk_idx_o = idx.
  - If rk_ready_i is high and idx != 0: key reg <= prev(key reg, idx), idx <= idx-1.
  - If rk_ready_i is high and idx == 0: state <= IDLE, and key reg is cleared when CLEAR_IDLE=1.
  - If rk_ready_i is low: all outputs hold stable; no combinational path from rk_ready_i to rk_o or rk_idx_o.
- prev() step, with inputs w0..w3 = round-r key and output p0..p3 = round-(r-1) key:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Throughput and latency:
  - Full throughput is 1 key per cycle.
  - A stream is 11 beats. The minimum from key acceptance to the last beat is 11 cycles.
  - After the last beat, one cycle in IDLE passes before the next key can be accepted.
- Flush: in any state, flush_i has priority over every other input.
  - Next state is IDLE; rk_valid_o=0 next cycle; idx=0; key reg cleared if CLEAR_IDLE.
  - The beat presented in the flush cycle counts as consumed only if rk_ready_i was also high; the consumer must discard the partial stream.
- rst_i has priority over flush_i. Reset mid-stream behaves the same as flush, plus all outputs take their reset values.
- key_valid_i while in EMIT is ignored; the key is not consumed (key_ready_o=0).
- rk_last_o is combinational from idx and state only.

Decomposition:
- aes_pkg (shared package):
  - word_t (logic [31:0]) and block_t (logic [127:0]).
  - Forward S-box constant table and sub_word() function.
  - Rcon table indexed 1..10.
  - inv_ks_state_e enum {IDLE, EMIT}.
- Sub-module aes_inv_key_step (purely combinational): inputs key and round index, output prev(key, idx). It reuses the aes_pkg S-box and is unit-testable on its own.
- Top level keeps only the FSM, the index counter and the key register.

Test Plan:
- Single stream, FIPS-197 A.1 vector, rk_ready_i=1 throughout:
  - Stimulus: key_i=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Beat 0: idx 10, rk_o equals key_i.
  - Beat 1: idx 9, rk_o=ac7766f319fadc2128d12941575c006e.
  - Beat 10: idx 0, rk_last_o=1, rk_o=2b7e151628aed2a6abf7158809cf4f3c.
  - 11 consecutive valid cycles.
- Backpressure: same key, rk_ready_i randomly low about 50% of cycles.
  - Identical 11-key sequence; rk_o and rk_idx_o stable whenever rk_valid_o=1 and rk_ready_i=0.
- Back-to-back: second key_valid_i held high from the first stream's start.
  - key_ready_o stays 0 until the cycle after idx-0 acceptance; the second stream begins with no lost or duplicated beat.
- Flush mid-stream: assert flush_i at idx 6.
  - Next cycle: rk_valid_o=0 and key_ready_o=1; rk_o=0 (CLEAR_IDLE=1).
  - A new key restarts at idx 10.
- Reset mid-stream: assert rst_i at idx 3 together with flush_i and key_valid_i.
  - All outputs at reset values next cycle; the key is not accepted.
- Step unit check: aes_inv_key_step driven with all 10 forward-schedule round keys of the A.1 vector.
  - Each output matches the preceding round key, and all 10 Rcon values are exercised.
